// File: rtl/sine_sweep_controller.sv
// Sine sweep controller: Avalon-MM register block, sample-rate divider,
// phase accumulator and dwell-based frequency stepping (IDLE/RUN/DONE).
module sine_sweep_controller #(
  parameter int unsigned DIV = 50
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ChipSelect,
  input  logic        Write,
  input  logic        Read,
  input  logic [1:0]  Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [9:0]  phase,
  output logic        sample_en,
  output logic        busy,
  output logic        done_irq
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [15:0] DivLast = 16'(DIV - 1);

  state_e state_q, state_d;

  // Bus-visible configuration registers
  logic        sweep_en_q, continuous_q;
  logic [7:0]  fcw_start_q, fcw_stop_q;
  logic [15:0] dwell_q;

  // Shadows captured at start; the running sweep only looks at these
  logic [7:0]  fcw_q, start_fcw_q, stop_fcw_q;
  logic [15:0] dwell_max_q, dwell_cnt_q;
  logic        sweep_sh_q, cont_sh_q;

  logic [15:0] div_q;
  logic [9:0]  phase_q;
  logic        done_q;
  logic [31:0] rdata_q;

  logic wr_ctrl, start_req, stop_req, clr_req;
  logic do_start, advance, do_step, do_wrap, set_done, dwell_last, step_up;

  // Upper write-data bits have no register behind them
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:16];

  assign wr_ctrl   = ChipSelect & Write & (Address == 2'd0);
  assign start_req = wr_ctrl & WriteData[0];
  assign stop_req  = wr_ctrl & WriteData[1];
  assign clr_req   = wr_ctrl & WriteData[4];

  assign dwell_last = (dwell_cnt_q == dwell_max_q - 16'd1);
  assign step_up    = (start_fcw_q < stop_fcw_q);

  assign phase    = phase_q;
  assign done_irq = done_q;
  assign ReadData = rdata_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and control strobes; stop beats start, start beats sweeping
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    advance   = 1'b0;
    do_step   = 1'b0;
    do_wrap   = 1'b0;
    set_done  = 1'b0;
    busy      = (state_q == StRun);
    sample_en = (state_q == StRun) && (div_q == DivLast);
    unique case (state_q)
      StIdle: begin
        if (start_req && !stop_req) begin
          do_start = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (stop_req) begin
          state_d = StIdle;
        end else if (start_req) begin
          do_start = 1'b1;
        end else begin
          advance = 1'b1;
          if (sample_en && sweep_sh_q && dwell_last) begin
            if (fcw_q != stop_fcw_q) begin
              do_step = 1'b1;
            end else if (cont_sh_q) begin
              do_wrap = 1'b1;
            end else begin
              set_done = 1'b1;
              state_d  = StDone;
            end
          end
        end
      end
      StDone: begin
        if (start_req && stop_req) begin
          state_d = StIdle;
        end else if (start_req) begin
          do_start = 1'b1;
          state_d  = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Configuration register writes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sweep_en_q   <= 1'b0;
      continuous_q <= 1'b0;
      fcw_start_q  <= 8'd0;
      fcw_stop_q   <= 8'd0;
      dwell_q      <= 16'd0;
    end else if (ChipSelect && Write) begin
      unique case (Address)
        2'd0: begin
          sweep_en_q   <= WriteData[2];
          continuous_q <= WriteData[3];
        end
        2'd1: fcw_start_q <= WriteData[7:0];
        2'd2: fcw_stop_q  <= WriteData[7:0];
        2'd3: dwell_q     <= WriteData[15:0];
        default: ;
      endcase
    end
  end

  // Sweep datapath: divider, phase accumulator, dwell counter, fcw stepping
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fcw_q       <= 8'd0;
      start_fcw_q <= 8'd0;
      stop_fcw_q  <= 8'd0;
      dwell_max_q <= 16'd0;
      dwell_cnt_q <= 16'd0;
      sweep_sh_q  <= 1'b0;
      cont_sh_q   <= 1'b0;
      div_q       <= 16'd0;
      phase_q     <= 10'd0;
    end else if (do_start) begin
      fcw_q       <= fcw_start_q;
      start_fcw_q <= fcw_start_q;
      stop_fcw_q  <= fcw_stop_q;
      dwell_max_q <= (dwell_q == 16'd0) ? 16'd1 : dwell_q;
      dwell_cnt_q <= 16'd0;
      // sweep_en/continuous come from the same CTRL write that starts
      sweep_sh_q  <= WriteData[2];
      cont_sh_q   <= WriteData[3];
      div_q       <= 16'd0;
      phase_q     <= 10'd0;
    end else if (advance) begin
      div_q <= sample_en ? 16'd0 : div_q + 16'd1;
      if (sample_en) begin
        phase_q <= phase_q + {2'b00, fcw_q};
        if (sweep_sh_q) begin
          dwell_cnt_q <= dwell_last ? 16'd0 : dwell_cnt_q + 16'd1;
        end
      end
      if (do_step) begin
        fcw_q <= step_up ? fcw_q + 8'd1 : fcw_q - 8'd1;
      end else if (do_wrap) begin
        fcw_q <= start_fcw_q;
      end
    end
  end

  // Sticky end-of-sweep flag; a set in the same cycle as a clear wins
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_q <= 1'b0;
    end else if (do_start) begin
      done_q <= 1'b0;
    end else if (set_done) begin
      done_q <= 1'b1;
    end else if (clr_req) begin
      done_q <= 1'b0;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q <= 32'd0;
    end else if (ChipSelect && Read) begin
      unique case (Address)
        2'd0: rdata_q <= {16'd0, fcw_q, 4'd0, continuous_q, sweep_en_q, done_q, busy};
        2'd1: rdata_q <= {24'd0, fcw_start_q};
        2'd2: rdata_q <= {24'd0, fcw_stop_q};
        2'd3: rdata_q <= {16'd0, dwell_q};
        default: rdata_q <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_sweep_controller.sv
// Directed self-checking bench for sine_sweep_controller with DIV=4.
module tb_sine_sweep_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ChipSelect = 1'b0;
  logic        Write = 1'b0;
  logic        Read = 1'b0;
  logic [1:0]  Address = 2'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic [9:0]  phase;
  logic        sample_en;
  logic        busy;
  logic        done_irq;

  int n_checks = 0;
  int n_fail = 0;

  sine_sweep_controller #(.DIV(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ChipSelect (ChipSelect),
    .Write      (Write),
    .Read       (Read),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .phase      (phase),
    .sample_en  (sample_en),
    .busy       (busy),
    .done_irq   (done_irq)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    ChipSelect = 1'b1; Write = 1'b1; Address = addr; WriteData = data;
    step();
    ChipSelect = 1'b0; Write = 1'b0; WriteData = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    ChipSelect = 1'b1; Read = 1'b1; Address = addr;
    step();
    ChipSelect = 1'b0; Read = 1'b0;
    data = ReadData;
  endtask

  // Cycles counted from 1 for the cycle we are in; returns the phase step of the pulse
  task automatic measure_pulse(output int cycles, output logic [9:0] delta);
    logic [9:0] old;
    cycles = 1;
    while (!sample_en && cycles < 40) begin
      step();
      cycles++;
    end
    old = phase;
    step();
    delta = phase - old;
  endtask

  initial begin
    int          per;
    logic [9:0]  d;
    logic [31:0] rd;
    logic        seen;
    int          exp_a[6] = '{10, 10, 11, 11, 12, 12};
    int          exp_b[7] = '{12, 11, 10, 12, 11, 10, 12};

    step(); step();
    Reset = 1'b0;
    check_eq("rst_phase", {22'd0, phase}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sample_en", {31'd0, sample_en}, 32'd0);
    check_eq("rst_done", {31'd0, done_irq}, 32'd0);
    check_eq("rst_rdata", ReadData, 32'd0);

    // Fixed tone, fcw 16
    bus_write(2'd1, 32'd16);
    bus_write(2'd0, 32'h1);
    check_eq("tone_busy", {31'd0, busy}, 32'd1);
    for (int p = 1; p <= 65; p++) begin
      measure_pulse(per, d);
      check_eq($sformatf("tone_period_%0d", p), per, 32'd4);
      if (p == 1 || p == 63 || p == 64)
        check_eq($sformatf("tone_phase_%0d", p), {22'd0, phase}, (p * 16) % 1024);
    end
    bus_write(2'd0, 32'h2);
    check_eq("stop_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= sample_en;
      step();
    end
    check_eq("stop_no_sample", {31'd0, seen}, 32'd0);
    check_eq("stop_phase_hold", {22'd0, phase}, 32'd16);

    // One-shot sweep up 10..12, dwell 2
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd12);
    bus_write(2'd3, 32'd2);
    bus_write(2'd0, 32'h5);
    check_eq("up_phase_clear", {22'd0, phase}, 32'd0);
    for (int p = 0; p < 6; p++) begin
      measure_pulse(per, d);
      check_eq($sformatf("up_fcw_%0d", p), {22'd0, d}, exp_a[p]);
    end
    check_eq("up_done", {31'd0, done_irq}, 32'd1);
    check_eq("up_busy", {31'd0, busy}, 32'd0);
    check_eq("up_phase", {22'd0, phase}, 32'd66);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= sample_en;
      step();
    end
    check_eq("done_no_sample", {31'd0, seen}, 32'd0);
    check_eq("done_phase_frozen", {22'd0, phase}, 32'd66);
    bus_read(2'd0, rd);
    check_eq("done_ctrl_read", rd, 32'h0C06);
    bus_read(2'd3, rd);
    check_eq("dwell_read", rd, 32'd2);

    // done_clr (sweep_en kept set)
    bus_write(2'd0, 32'h14);
    check_eq("clr_done", {31'd0, done_irq}, 32'd0);
    bus_read(2'd0, rd);
    check_eq("clr_ctrl_read", rd, 32'h0C04);

    // Continuous sweep down 12..10, dwell 0 treated as 1
    bus_write(2'd1, 32'd12);
    bus_write(2'd2, 32'd10);
    bus_write(2'd3, 32'd0);
    bus_write(2'd0, 32'hD);
    for (int p = 0; p < 7; p++) begin
      measure_pulse(per, d);
      check_eq($sformatf("dn_fcw_%0d", p), {22'd0, d}, exp_b[p]);
    end
    check_eq("dn_done_low", {31'd0, done_irq}, 32'd0);
    // FCW_STOP change mid-sweep leaves the running sweep alone
    bus_write(2'd2, 32'd11);
    for (int p = 7; p < 12; p++) begin
      measure_pulse(per, d);
      check_eq($sformatf("dn_fcw_%0d", p), {22'd0, d}, exp_b[p % 3 + 3]);
    end
    bus_read(2'd2, rd);
    check_eq("stop_reg_read", rd, 32'd11);

    // Restart during RUN: one-shot 12..11
    bus_write(2'd0, 32'h5);
    check_eq("restart_busy", {31'd0, busy}, 32'd1);
    check_eq("restart_phase", {22'd0, phase}, 32'd0);
    measure_pulse(per, d);
    check_eq("restart_period", per, 32'd4);
    check_eq("restart_fcw0", {22'd0, d}, 32'd12);
    measure_pulse(per, d);
    check_eq("restart_fcw1", {22'd0, d}, 32'd11);
    check_eq("restart_done", {31'd0, done_irq}, 32'd1);
    check_eq("restart_phase_end", {22'd0, phase}, 32'd23);

    // Start from DONE, then start+stop together
    bus_write(2'd0, 32'h5);
    check_eq("start_clears_done", {31'd0, done_irq}, 32'd0);
    measure_pulse(per, d);
    check_eq("ss_pre_phase", {22'd0, phase}, 32'd12);
    bus_write(2'd0, 32'h3);
    check_eq("ss_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= sample_en;
      step();
    end
    check_eq("ss_no_sample", {31'd0, seen}, 32'd0);
    check_eq("ss_phase_hold", {22'd0, phase}, 32'd12);

    // Reset mid-sweep
    bus_write(2'd0, 32'h1);
    measure_pulse(per, d);
    check_eq("tone2_fcw", {22'd0, d}, 32'd12);
    bus_read(2'd2, rd);
    check_eq("pre_rst_read", rd, 32'd11);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("mid_rst_phase", {22'd0, phase}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_sample_en", {31'd0, sample_en}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done_irq}, 32'd0);
    check_eq("mid_rst_rdata", ReadData, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= done_irq | busy | sample_en;
      step();
    end
    check_eq("post_rst_quiet", {31'd0, seen}, 32'd0);
    bus_read(2'd1, rd);
    check_eq("post_rst_cfg", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_sweep_controller.md
SINE_SWEEP_CONTROLLER -- requirements
Module: sine_sweep_controller

Interface
REQ-001 Parameter DIV, default 50: Clk cycles per sample tick (50 MHz -> 1 MHz); legal range 2..65535.
REQ-002 Clk  in  1  system clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ChipSelect  in  1  Avalon-MM slave select.
REQ-005 Write  in  1  write strobe, qualified by ChipSelect.
REQ-006 Read  in  1  read strobe, qualified by ChipSelect.
REQ-007 Address  in  2  register select: 0 CTRL/STATUS, 1 FCW_START, 2 FCW_STOP, 3 DWELL.
REQ-008 WriteData  in  32  write data.
REQ-009 ReadData  out  32  read data, registered, valid the cycle after the Read strobe.
REQ-010 phase  out  10  phase word to the sine generator, registered.
REQ-011 sample_en  out  1  one-Clk pulse per sample tick; the generator advances only on this pulse.
REQ-012 busy  out  1  high in state RUN.
REQ-013 done_irq  out  1  sticky end-of-sweep flag, level output.

Function
REQ-014 Write fields: CTRL bit0 start, bit1 stop, bit2 sweep_en, bit3 continuous, bit4 done_clr (bits 0, 1 and 4 self-clearing); FCW_START[7:0]; FCW_STOP[7:0]; DWELL[15:0]. Unused bits are ignored.
REQ-015 CTRL read: bit0 busy, bit1 done_irq, bit2 sweep_en, bit3 continuous, bits[15:8] current fcw, all other bits 0. Config registers read back as written, zero-extended.
REQ-016 The state machine has states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start; DONE->RUN on start; RUN->IDLE on stop; RUN->DONE at end of a one-shot sweep.
REQ-018 Start latches the shadow values fcw<=FCW_START, stop_fcw<=FCW_STOP, dwell_max<=max(DWELL,1), and clears phase, the divider, the dwell counter and done_irq.
REQ-019 Config writes during RUN update the registers only; they take effect at the next start.
REQ-020 Start during RUN restarts the sequence per REQ-018 in the next cycle; no IDLE cycle is inserted.
REQ-021 Start and stop in the same write: stop wins, next state IDLE.
REQ-022 The divider counts 0..DIV-1 only in RUN; sample_en is asserted in the cycle the count equals DIV-1; the first pulse occurs DIV cycles after entry to RUN.
REQ-023 On each sample_en, phase <= (phase + fcw) mod 1024, with fcw zero-extended; fcw=0 holds phase.
REQ-024 With sweep_en=0: fixed tone at FCW_START until stop; the dwell logic is inactive.
REQ-025 With sweep_en=1: the dwell counter counts sample_en pulses; on the dwell_max-th pulse the counter clears and fcw steps by 1 toward stop_fcw (up if start<stop, down if start>stop).
REQ-026 When dwell expires with fcw==stop_fcw: if continuous=1, fcw<=FCW_START shadow and RUN continues; otherwise go to DONE and set done_irq.
REQ-027 If FCW_START==FCW_STOP with sweep_en=1: one dwell period, then DONE, or a repeat of the period if continuous.
REQ-028 In DONE and IDLE: sample_en=0; phase and fcw hold their last values.
REQ-029 done_irq clears on done_clr or start; if done_clr coincides with the set event, set wins.
REQ-030 fcw stepping never wraps: the 8-bit value stays between the start and stop shadows inclusive.

Reset
REQ-031 On Reset=1 at a clock edge: state IDLE; phase, fcw, dividers, counters, all config registers, ReadData, sample_en, busy and done_irq become 0.
REQ-032 Reset has priority over any simultaneous bus access; Reset asserted mid-sweep aborts it with no done_irq.

Verification (DIV=4)
REQ-033 FCW_START=16, sweep_en=0, start -> sample_en every 4 cycles, first at cycle 4; phase 16, 32, ... 1008, 0 (wrap); busy=1.
REQ-034 START=10, STOP=12, DWELL=2, one-shot -> fcw 10,10,11,11,12,12 per pulse, then DONE, done_irq=1, busy=0, phase frozen.
REQ-035 START=12, STOP=10, DWELL=0, continuous -> fcw 12, 11, 10, 12, 11, ... with one pulse per step; done_irq stays 0.
REQ-036 FCW_STOP written mid-sweep -> current sweep unaffected; new value used after the next start; read of Address 2 returns the new value.
REQ-037 Start+stop in the same write during RUN -> IDLE, sample_en=0; Reset mid-sweep -> all outputs 0 on the next cycle.
REQ-038 done_irq=1, then done_clr -> CTRL read bit1=0 on the read cycle after the clear.
